// File: rtl/wb_la_arbiter_pkg.sv
// Shared types and constants for the Wishbone / Logic-Analyzer register-bus arbiter.
package wb_la_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESP    = 2'd2,
      LA_WAIT = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_WB = 1'b0,
      GNT_LA = 1'b1
   } grant_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_DEAD;
   localparam int          TIMER_W          = 16;

endpackage

// File: rtl/wb_la_arbiter_timer.sv
// Loadable down-counter used to bound a downstream access; expired is high while the count is zero.
module wb_la_arbiter_timer
   import wb_la_arbiter_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/wb_la_arbiter.sv
// Round-robin arbiter sharing the core register bus between the Wishbone slave port and an LA debug master.
// Build option: define ARB_TIMEOUT_EN to add the BUSY timeout counter, timeout_o and the ERR_DATA path.
module wb_la_arbiter
   import wb_la_arbiter_pkg::*;
#(
   parameter int          LA_ADR_W = 16,
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic                wbs_cyc_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_we_i,
   input  logic [31:0]         wbs_adr_i,
   input  logic [31:0]         wbs_dat_i,
   input  logic [3:0]          wbs_sel_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   input  logic                la_req_i,
   input  logic                la_we_i,
   input  logic [LA_ADR_W-1:0] la_adr_i,
   input  logic [31:0]         la_dat_i,
   output logic                la_ack_o,
   output logic [31:0]         la_dat_o,
   output logic                m_cyc_o,
   output logic                m_we_o,
   output logic [31:0]         m_adr_o,
   output logic [31:0]         m_dat_o,
   output logic [3:0]          m_sel_o,
   input  logic                m_ack_i,
   input  logic [31:0]         m_dat_i,
   output logic                timeout_o
);

   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("wb_la_arbiter: TIMEOUT must be within 2..65535");
   end

   arb_state_e  state_q, state_d;
   grant_e      last_q, last_d;
   logic        abort_q, abort_d;
   logic        m_cyc_q, m_cyc_d;
   logic        m_we_q, m_we_d;
   logic [31:0] m_adr_q, m_adr_d;
   logic [31:0] m_dat_q, m_dat_d;
   logic [3:0]  m_sel_q, m_sel_d;
   logic        wbs_ack_q, wbs_ack_d;
   logic [31:0] wbs_dat_q, wbs_dat_d;
   logic        la_ack_q, la_ack_d;
   logic [31:0] la_dat_q, la_dat_d;
   logic [31:0] rdata_q, rdata_d;
   logic        timeout_q, timeout_d;

   logic        wb_pend, la_pend, expired;
   logic [31:0] cap_data;

   assign wb_pend  = wbs_cyc_i & wbs_stb_i;
   assign la_pend  = la_req_i & ~la_ack_q;
   assign cap_data = m_ack_i ? m_dat_i : ERR_DATA;

`ifdef ARB_TIMEOUT_EN
   wb_la_arbiter_timer #(.W(TIMER_W)) u_timer (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_ni),
      .load     (state_q == IDLE),
      .en       (state_q == BUSY),
      .load_val (TIMER_W'(TIMEOUT - 1)),
      .expired  (expired)
   );
`else
   assign expired = 1'b0;
`endif

   // last_q doubles as the current grant once a transaction has started
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      abort_d   = abort_q;
      m_cyc_d   = m_cyc_q;
      m_we_d    = m_we_q;
      m_adr_d   = m_adr_q;
      m_dat_d   = m_dat_q;
      m_sel_d   = m_sel_q;
      wbs_ack_d = 1'b0;
      wbs_dat_d = wbs_dat_q;
      la_ack_d  = la_ack_q;
      la_dat_d  = la_dat_q;
      rdata_d   = rdata_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wb_pend && (!la_pend || last_q == GNT_LA)) begin
               last_d  = GNT_WB;
               abort_d = 1'b0;
               m_cyc_d = 1'b1;
               m_we_d  = wbs_we_i;
               m_adr_d = wbs_adr_i;
               m_dat_d = wbs_dat_i;
               m_sel_d = wbs_sel_i;
               state_d = BUSY;
            end else if (la_pend) begin
               last_d  = GNT_LA;
               abort_d = 1'b0;
               m_cyc_d = 1'b1;
               m_we_d  = la_we_i;
               m_adr_d = 32'(la_adr_i);
               m_dat_d = la_dat_i;
               m_sel_d = 4'hF;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (last_q == GNT_WB && !wbs_cyc_i) begin
               abort_d = 1'b1;
            end
            // an ack in the expiry cycle takes priority over the timeout
            if (m_ack_i || expired) begin
               m_cyc_d   = 1'b0;
               timeout_d = ~m_ack_i;
               rdata_d   = cap_data;
               if (last_q == GNT_LA) begin
                  state_d = RESP;
               end else if (abort_d) begin
                  state_d = IDLE;
               end else begin
                  wbs_ack_d = 1'b1;
                  wbs_dat_d = cap_data;
                  state_d   = RESP;
               end
            end
         end
         RESP: begin
            if (last_q == GNT_LA) begin
               la_ack_d = 1'b1;
               la_dat_d = rdata_q;
               state_d  = LA_WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         LA_WAIT: begin
            if (!la_req_i) begin
               la_ack_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= IDLE;
         last_q    <= GNT_LA;
         abort_q   <= 1'b0;
         m_cyc_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_adr_q   <= '0;
         m_dat_q   <= '0;
         m_sel_q   <= '0;
         wbs_ack_q <= 1'b0;
         wbs_dat_q <= '0;
         la_ack_q  <= 1'b0;
         la_dat_q  <= '0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         abort_q   <= abort_d;
         m_cyc_q   <= m_cyc_d;
         m_we_q    <= m_we_d;
         m_adr_q   <= m_adr_d;
         m_dat_q   <= m_dat_d;
         m_sel_q   <= m_sel_d;
         wbs_ack_q <= wbs_ack_d;
         wbs_dat_q <= wbs_dat_d;
         la_ack_q  <= la_ack_d;
         la_dat_q  <= la_dat_d;
         rdata_q   <= rdata_d;
         timeout_q <= timeout_d;
      end
   end

   assign wbs_ack_o = wbs_ack_q;
   assign wbs_dat_o = wbs_dat_q;
   assign la_ack_o  = la_ack_q;
   assign la_dat_o  = la_dat_q;
   assign m_cyc_o   = m_cyc_q;
   assign m_we_o    = m_we_q;
   assign m_adr_o   = m_adr_q;
   assign m_dat_o   = m_dat_q;
   assign m_sel_o   = m_sel_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_la_arbiter.sv
// Self-checking bench for wb_la_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin model. Timeout scenarios depend on ARB_TIMEOUT_EN.
module tb_wb_la_arbiter;

   localparam int TO   = 8;
   localparam int LA_W = 16;

   logic            clk;
   logic            rst_n;
   logic            wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [31:0]     wbs_adr_i, wbs_dat_i;
   logic [3:0]      wbs_sel_i;
   logic            wbs_ack_o;
   logic [31:0]     wbs_dat_o;
   logic            la_req_i, la_we_i;
   logic [LA_W-1:0] la_adr_i;
   logic [31:0]     la_dat_i;
   logic            la_ack_o;
   logic [31:0]     la_dat_o;
   logic            m_cyc_o, m_we_o;
   logic [31:0]     m_adr_o, m_dat_o;
   logic [3:0]      m_sel_o;
   logic            m_ack_i;
   logic [31:0]     m_dat_i;
   logic            timeout_o;

   int checks   = 0;
   int failures = 0;

   // transaction-level model state
   bit          model_last_la;
   logic [31:0] model_wb_dat, model_la_dat;

   // fields of the transaction currently being offered
   bit            tx_wb_we, tx_la_we;
   logic [31:0]   tx_wb_adr, tx_wb_dat, tx_la_dat;
   logic [3:0]    tx_wb_sel;
   logic [LA_W-1:0] tx_la_adr;

   wb_la_arbiter #(.LA_ADR_W(LA_W), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_DEAD)) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .la_req_i  (la_req_i),
      .la_we_i   (la_we_i),
      .la_adr_i  (la_adr_i),
      .la_dat_i  (la_dat_i),
      .la_ack_o  (la_ack_o),
      .la_dat_o  (la_dat_o),
      .m_cyc_o   (m_cyc_o),
      .m_we_o    (m_we_o),
      .m_adr_o   (m_adr_o),
      .m_dat_o   (m_dat_o),
      .m_sel_o   (m_sel_o),
      .m_ack_i   (m_ack_i),
      .m_dat_i   (m_dat_i),
      .timeout_o (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit do_wb, input bit do_la);
      wbs_cyc_i = do_wb;
      wbs_stb_i = do_wb;
      wbs_we_i  = tx_wb_we;
      wbs_adr_i = tx_wb_adr;
      wbs_dat_i = tx_wb_dat;
      wbs_sel_i = tx_wb_sel;
      la_req_i  = do_la;
      la_we_i   = tx_la_we;
      la_adr_i  = tx_la_adr;
      la_dat_i  = tx_la_dat;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = 0; wbs_dat_i = 0; wbs_sel_i = 0;
      la_req_i = 0; la_we_i = 0; la_adr_i = 0; la_dat_i = 0;
      m_ack_i = 0; m_dat_i = 0;
      tick();
      tick();
      rst_n = 1'b1;
      model_last_la = 1'b1;
      model_wb_dat  = 32'h0;
      model_la_dat  = 32'h0;
      tick();
   endtask

   task automatic randomTx();
      tx_wb_we  = 1'($urandom_range(0, 1));
      tx_wb_adr = $urandom & 32'hFFFF_FFFC;
      tx_wb_dat = $urandom;
      tx_wb_sel = 4'($urandom_range(1, 14));
      tx_la_we  = 1'($urandom_range(0, 1));
      tx_la_adr = LA_W'($urandom);
      tx_la_dat = $urandom;
   endtask

   // Act as downstream slave for one access and finish the handshake of the expected master.
   task automatic serve(input bit is_la);
      int n;
      int d;
      logic [31:0] rd;
      n = 0;
      while (m_cyc_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checkOutput("m_cyc_grant", m_cyc_o, 1);
      checkOutput("m_we", m_we_o, is_la ? tx_la_we : tx_wb_we);
      checkOutput("m_adr", m_adr_o, is_la ? 32'(tx_la_adr) : tx_wb_adr);
      checkOutput("m_dat", m_dat_o, is_la ? tx_la_dat : tx_wb_dat);
      checkOutput("m_sel", m_sel_o, is_la ? 4'hF : tx_wb_sel);
      d = $urandom_range(0, 3);
      repeat (d) begin
         tick();
         checkOutput("m_adr_hold", m_adr_o, is_la ? 32'(tx_la_adr) : tx_wb_adr);
      end
      rd = $urandom;
      m_ack_i = 1'b1;
      m_dat_i = rd;
      tick();
      m_ack_i = 1'b0;
      m_dat_i = $urandom;
      checkOutput("m_cyc_drop", m_cyc_o, 0);
      if (!is_la) begin
         checkOutput("wbs_ack", wbs_ack_o, 1);
         checkOutput("wbs_dat", wbs_dat_o, rd);
         checkOutput("la_dat_hold", la_dat_o, model_la_dat);
         model_wb_dat = rd;
         wbs_cyc_i = 1'b0;
         wbs_stb_i = 1'b0;
         tick();
         checkOutput("wbs_ack_pulse", wbs_ack_o, 0);
      end else begin
         checkOutput("la_ack_early", la_ack_o, 0);
         tick();
         checkOutput("la_ack", la_ack_o, 1);
         checkOutput("la_dat", la_dat_o, rd);
         checkOutput("wbs_dat_hold", wbs_dat_o, model_wb_dat);
         model_la_dat = rd;
         la_req_i = 1'b0;
         tick();
         checkOutput("la_ack_clear", la_ack_o, 0);
      end
   endtask

   // Offer requests and serve them in the order the round-robin rule dictates.
   task automatic runTxn(input bit do_wb, input bit do_la);
      bit first_la;
      randomTx();
      applyStimulus(do_wb, do_la);
      if (do_wb && do_la) first_la = !model_last_la;
      else                first_la = do_la;
      serve(first_la);
      model_last_la = first_la;
      if (do_wb && do_la) begin
         serve(!first_la);
         model_last_la = !first_la;
      end
   endtask

   initial begin
      int n;
      int mode;

      $display("[TB] starting wb_la_arbiter bench");
      tx_wb_we = 0; tx_wb_adr = 0; tx_wb_dat = 0; tx_wb_sel = 0;
      tx_la_we = 0; tx_la_adr = 0; tx_la_dat = 0;
      rst_n = 1'b0;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = 0; wbs_dat_i = 0; wbs_sel_i = 0;
      la_req_i = 0; la_we_i = 0; la_adr_i = 0; la_dat_i = 0;
      m_ack_i = 0; m_dat_i = 0;
      tick();
      tick();
      checkOutput("rst_wbs_ack", wbs_ack_o, 0);
      checkOutput("rst_la_ack", la_ack_o, 0);
      checkOutput("rst_m_cyc", m_cyc_o, 0);
      checkOutput("rst_m_we", m_we_o, 0);
      checkOutput("rst_timeout", timeout_o, 0);
      checkOutput("rst_m_adr", m_adr_o, 0);
      checkOutput("rst_m_dat", m_dat_o, 0);
      checkOutput("rst_m_sel", m_sel_o, 0);
      checkOutput("rst_wbs_dat", wbs_dat_o, 0);
      checkOutput("rst_la_dat", la_dat_o, 0);
      rst_n = 1'b1;
      model_last_la = 1'b1;
      model_wb_dat  = 32'h0;
      model_la_dat  = 32'h0;
      tick();

      $display("[TB] directed WB write");
      tx_wb_we = 1; tx_wb_adr = 32'h3000_0004; tx_wb_dat = 32'h1234_5678; tx_wb_sel = 4'hF;
      applyStimulus(1, 0);
      tick();
      checkOutput("wr_m_cyc", m_cyc_o, 1);
      checkOutput("wr_m_we", m_we_o, 1);
      checkOutput("wr_m_adr", m_adr_o, 32'h3000_0004);
      checkOutput("wr_m_dat", m_dat_o, 32'h1234_5678);
      checkOutput("wr_m_sel", m_sel_o, 4'hF);
      tick();
      checkOutput("wr_no_ack_c2", wbs_ack_o, 0);
      tick();
      checkOutput("wr_no_ack_c3", wbs_ack_o, 0);
      m_ack_i = 1'b1;
      m_dat_i = 32'h0BAD_BEEF;
      tick();
      m_ack_i = 1'b0;
      checkOutput("wr_ack_c4", wbs_ack_o, 1);
      checkOutput("wr_dat_c4", wbs_dat_o, 32'h0BAD_BEEF);
      checkOutput("wr_m_cyc_low", m_cyc_o, 0);
      model_wb_dat = 32'h0BAD_BEEF;
      model_last_la = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      tick();
      checkOutput("wr_ack_single", wbs_ack_o, 0);

      $display("[TB] directed LA read");
      tx_la_we = 0; tx_la_adr = 16'h0010; tx_la_dat = 32'h5555_AAAA;
      applyStimulus(0, 1);
      tick();
      checkOutput("la_m_cyc", m_cyc_o, 1);
      checkOutput("la_m_adr", m_adr_o, 32'h0000_0010);
      checkOutput("la_m_sel", m_sel_o, 4'hF);
      checkOutput("la_m_we", m_we_o, 0);
      m_ack_i = 1'b1;
      m_dat_i = 32'hCAFE_F00D;
      tick();
      m_ack_i = 1'b0;
      checkOutput("la_ack_resp", la_ack_o, 0);
      tick();
      checkOutput("la_ack_set", la_ack_o, 1);
      checkOutput("la_dat_set", la_dat_o, 32'hCAFE_F00D);
      repeat (3) tick();
      checkOutput("la_ack_held", la_ack_o, 1);
      checkOutput("la_dat_held", la_dat_o, 32'hCAFE_F00D);
      la_req_i = 1'b0;
      tick();
      checkOutput("la_ack_cleared", la_ack_o, 0);
      checkOutput("la_dat_kept", la_dat_o, 32'hCAFE_F00D);
      checkOutput("wbs_dat_kept", wbs_dat_o, 32'h0BAD_BEEF);

      $display("[TB] simultaneous requests from reset");
      doReset();
      runTxn(1, 1);
      runTxn(1, 1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 12; i++) begin
         mode = $urandom_range(0, 2);
         runTxn(mode != 1, mode != 0);
      end

`ifdef ARB_TIMEOUT_EN
      $display("[TB] timeout with no downstream ack");
      randomTx();
      tx_wb_we = 0;
      applyStimulus(1, 0);
      tick();
      n = 0;
      while (m_cyc_o === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      checkOutput("to_busy_cycles", 32'(n), TO);
      checkOutput("to_pulse", timeout_o, 1);
      checkOutput("to_wbs_ack", wbs_ack_o, 1);
      checkOutput("to_err_data", wbs_dat_o, 32'hDEAD_DEAD);
      checkOutput("to_m_cyc_low", m_cyc_o, 0);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      tick();
      checkOutput("to_pulse_single", timeout_o, 0);
      model_wb_dat = 32'hDEAD_DEAD;
      model_last_la = 1'b0;

      $display("[TB] ack in the timeout cycle");
      randomTx();
      applyStimulus(1, 0);
      tick();
      repeat (TO - 1) tick();
      checkOutput("race_m_cyc", m_cyc_o, 1);
      m_ack_i = 1'b1;
      m_dat_i = 32'h600D_F00D;
      tick();
      m_ack_i = 1'b0;
      checkOutput("race_wbs_ack", wbs_ack_o, 1);
      checkOutput("race_dat", wbs_dat_o, 32'h600D_F00D);
      checkOutput("race_no_timeout", timeout_o, 0);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      tick();
      checkOutput("race_no_timeout_after", timeout_o, 0);
      model_wb_dat = 32'h600D_F00D;
      model_last_la = 1'b0;

      randomTx();
      applyStimulus(1, 0);
      tick();
      tick();
`else
      $display("[TB] no timeout build: BUSY waits for ack");
      randomTx();
      applyStimulus(1, 0);
      repeat (50) tick();
      checkOutput("nto_m_cyc_high", m_cyc_o, 1);
      checkOutput("nto_timeout_low", timeout_o, 0);
      checkOutput("nto_no_ack", wbs_ack_o, 0);
`endif

      $display("[TB] asynchronous reset during BUSY");
      checkOutput("pre_rst_m_cyc", m_cyc_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_m_cyc", m_cyc_o, 0);
      checkOutput("async_rst_m_adr", m_adr_o, 0);
      checkOutput("async_rst_wbs_dat", wbs_dat_o, 0);
      checkOutput("async_rst_timeout", timeout_o, 0);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      tick();
      rst_n = 1'b1;
      model_last_la = 1'b1;
      model_wb_dat  = 32'h0;
      model_la_dat  = 32'h0;
      tick();
      runTxn(1, 0);
      runTxn(1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
